// File: rtl/xtalk_pkg.sv
// rtl/xtalk_pkg.sv - shared types and default sizes for the crosstalk window controller
package xtalk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MEASURE,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  localparam int COUNT_W_DEF       = 8;
  localparam int WIN_W_DEF         = 16;
  localparam int CLEAR_CYCLES_DEF  = 2;
  localparam int SETTLE_CYCLES_DEF = 3;
  localparam int WID_W             = 4;

  // Phase timer must hold the full window length as well as the longer fixed phase.
  function automatic int timer_width(input int win_w, input int clr, input int stl);
    int m;
    int pw;
    m  = (clr > stl) ? clr : stl;
    pw = $clog2(m + 1);
    return (win_w > pw) ? win_w : pw;
  endfunction

endpackage

// File: rtl/xtalk_phase_timer.sv
// rtl/xtalk_phase_timer.sv - loadable down-counter, done high in the final cycle of a phase
module xtalk_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A phase loaded with N lasts N cycles: the count reads N..1 and stops at 0.
  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/xtalk_window_ctrl.sv
// rtl/xtalk_window_ctrl.sv - clear/gate/settle/capture sequencer for the crosstalk event counter
module xtalk_window_ctrl
  import xtalk_pkg::*;
#(
  parameter int COUNT_W       = COUNT_W_DEF,
  parameter int WIN_W         = WIN_W_DEF,
  parameter int CLEAR_CYCLES  = CLEAR_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               continuous_i,
  input  logic               abort_i,
  input  logic [WIN_W-1:0]   win_len_i,
  input  logic [COUNT_W-1:0] cnt_value_i,
  output logic               cnt_clear_o,
  output logic               cnt_gate_o,
  output logic [COUNT_W-1:0] result_o,
  output logic               result_sat_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [WID_W-1:0]   window_id_o,
  output logic               busy_o
);

  localparam int TW = timer_width(WIN_W, CLEAR_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0] CLR_LD = TW'(CLEAR_CYCLES);
  localparam logic [TW-1:0] STL_LD = TW'(SETTLE_CYCLES);

  state_e             state_q;
  logic [WIN_W-1:0]   win_q;
  logic               clear_q;
  logic               gate_q;
  logic [COUNT_W-1:0] result_q;
  logic               sat_q;
  logic               valid_q;
  logic [WID_W-1:0]   wid_q;

  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_done;
  logic               abort_act;
  logic               hs;
  logic               start_ok;

  assign abort_act = abort_i && (state_q != ST_IDLE);
  assign hs        = valid_q && result_ready_i;
  assign start_ok  = start_i && (win_len_i != '0);

  // Timer is reloaded on the same edge the FSM enters CLEAR, MEASURE or SETTLE.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!abort_act) begin
      case (state_q)
        ST_IDLE:    if (start_ok)             begin tmr_load = 1'b1; tmr_val = CLR_LD;     end
        ST_CLEAR:   if (tmr_done)             begin tmr_load = 1'b1; tmr_val = TW'(win_q); end
        ST_MEASURE: if (tmr_done)             begin tmr_load = 1'b1; tmr_val = STL_LD;     end
        ST_HOLD:    if (hs && continuous_i)   begin tmr_load = 1'b1; tmr_val = CLR_LD;     end
        default: ;
      endcase
    end
  end

  xtalk_phase_timer #(.W(TW)) u_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .done_o    (tmr_done)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      clear_q  <= 1'b1;
      gate_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      wid_q    <= '0;
    end else if (abort_act) begin
      state_q <= ST_IDLE;
      clear_q <= 1'b1;
      gate_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clear_q <= 1'b1;
          gate_q  <= 1'b0;
          if (start_ok) begin
            win_q   <= win_len_i;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (tmr_done) begin
            state_q <= ST_MEASURE;
            clear_q <= 1'b0;
            gate_q  <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (tmr_done) begin
            state_q <= ST_SETTLE;
            gate_q  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (tmr_done) begin
            result_q <= cnt_value_i;
            sat_q    <= &cnt_value_i;
            valid_q  <= 1'b1;
            state_q  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hs) begin
            valid_q <= 1'b0;
            wid_q   <= wid_q + WID_W'(1);
            clear_q <= 1'b1;
            state_q <= continuous_i ? ST_CLEAR : ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          clear_q <= 1'b1;
          gate_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_clear_o    = clear_q;
  assign cnt_gate_o     = gate_q;
  assign result_o       = result_q;
  assign result_sat_o   = sat_q;
  assign result_valid_o = valid_q;
  assign window_id_o    = wid_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xtalk_window_ctrl.sv
// tb/tb_xtalk_window_ctrl.sv - self-checking bench for xtalk_window_ctrl
module tb_xtalk_window_ctrl;

  localparam int C = 2;
  localparam int S = 3;

  logic        clk_i = 0;
  logic        reset_n_i = 0;
  logic        start_i = 0;
  logic        continuous_i = 0;
  logic        abort_i = 0;
  logic [15:0] win_len_i = 0;
  logic [7:0]  cnt_value_i;
  logic        cnt_clear_o, cnt_gate_o, result_sat_o, result_valid_o, busy_o;
  logic        result_ready_i = 0;
  logic [7:0]  result_o;
  logic [3:0]  window_id_o;

  xtalk_window_ctrl #(.COUNT_W(8), .WIN_W(16), .CLEAR_CYCLES(C), .SETTLE_CYCLES(S)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .continuous_i(continuous_i),
    .abort_i(abort_i), .win_len_i(win_len_i), .cnt_value_i(cnt_value_i),
    .cnt_clear_o(cnt_clear_o), .cnt_gate_o(cnt_gate_o), .result_o(result_o),
    .result_sat_o(result_sat_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i), .window_id_o(window_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // External event counter: cleared by cnt_clear, counts ev while gated.
  logic       ev = 0;
  logic [7:0] ext_cnt = 0;
  assign cnt_value_i = ext_cnt;
  always @(posedge clk_i) begin
    if (cnt_clear_o)           ext_cnt <= 8'd0;
    else if (cnt_gate_o && ev) ext_cnt <= ext_cnt + 8'd1;
  end

  // Reference model: a window is a timeline relative to its accepting edge t0.
  int cyc = 0, t0 = 0, mw = 0, mcnt = 0, mres = 0, mwid = 0;
  bit mbusy = 0;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mbusy = 0; mres = 0; mwid = 0; mcnt = 0;
    end else begin
      int dp;
      dp = cyc - t0 + 1;
      cyc++;
      if (mbusy && abort_i) begin
        mbusy = 0;
      end else if (!mbusy) begin
        if (start_i && win_len_i != 0) begin
          mbusy = 1; mw = win_len_i; t0 = cyc; mcnt = 0;
        end
      end else begin
        if (dp >= C + 1 && dp <= C + mw && ev) mcnt++;
        if (dp == C + mw + S) mres = mcnt % 256;
        if (dp >= C + mw + S + 1 && result_ready_i) begin
          mwid = (mwid + 1) % 16;
          if (continuous_i) begin t0 = cyc; mcnt = 0; end
          else mbusy = 0;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    int d;
    d = cyc - t0 + 1;
    chk("m_busy",  busy_o,         mbusy);
    chk("m_clear", cnt_clear_o,    !mbusy || (d >= 1 && d <= C));
    chk("m_gate",  cnt_gate_o,     mbusy && d >= C + 1 && d <= C + mw);
    chk("m_valid", result_valid_o, mbusy && d >= C + mw + S + 1);
    chk("m_result", result_o,      mres);
    chk("m_sat",   result_sat_o,   mres == 255);
    chk("m_wid",   window_id_o,    mwid);
  end

  int per = 0;

  task automatic step();
    int k;
    @(posedge clk_i);
    #1;
    k = (cyc - t0 + 1) - C;
    if (per == 0) ev = $urandom_range(0, 1);
    else          ev = mbusy && k >= 1 && (k % per) == 0;
  endtask

  typedef struct {
    int win;
    int per;
    int exp_res;
    bit exp_sat;
  } vec_t;

  vec_t tbl[6];
  int acc = 0;

  task automatic run_vec(input vec_t v);
    int last;
    per = v.per;
    win_len_i = v.win[15:0];
    start_i = 1;
    step();
    start_i = 0;
    last = C + v.win + S + 1;
    for (int d = 1; d <= last; d++) begin
      chk("t_clear", cnt_clear_o,    d <= C);
      chk("t_gate",  cnt_gate_o,     d >= C + 1 && d <= C + v.win);
      chk("t_valid", result_valid_o, d == last);
      if (d < last) step();
    end
    chk("t_result", result_o, v.exp_res);
    chk("t_sat",    result_sat_o, v.exp_sat);
    result_ready_i = 1;
    step();
    result_ready_i = 0;
    acc++;
    chk("t_valid_drop", result_valid_o, 0);
    chk("t_wid", window_id_o, acc % 16);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!result_valid_o && n < 2000) begin step(); n++; end
    chk(name, result_valid_o, 1);
  endtask

  initial begin
    tbl[0] = '{10, 3, 3, 0};
    tbl[1] = '{1, 1, 1, 0};
    tbl[2] = '{7, 2, 3, 0};
    tbl[3] = '{20, 5, 4, 0};
    tbl[4] = '{255, 1, 255, 1};
    tbl[5] = '{300, 1, 44, 0};

    repeat (3) step();
    chk("rst_clear", cnt_clear_o, 1);
    chk("rst_gate", cnt_gate_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_sat", result_sat_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_wid", window_id_o, 0);
    chk("rst_busy", busy_o, 0);
    reset_n_i = 1;
    step();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Zero-length start ignored; start during MEASURE ignored.
    per = 2;
    win_len_i = 0; start_i = 1; step(); start_i = 0;
    chk("zero_len_busy", busy_o, 0);
    win_len_i = 8; start_i = 1; step(); start_i = 0;
    repeat (C + 2) step();
    chk("mid_gate", cnt_gate_o, 1);
    win_len_i = 3; start_i = 1; step(); start_i = 0;
    wait_valid("restart_valid_timeout");
    chk("restart_result", result_o, 4);
    result_ready_i = 1; step(); result_ready_i = 0; acc++;

    // Backpressure in HOLD with continuous re-arm.
    per = 1; continuous_i = 1;
    win_len_i = 5; start_i = 1; step(); start_i = 0;
    wait_valid("bp_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      step();
      if (i % 5 == 0) begin
        chk("bp_result", result_o, 5);
        chk("bp_gate", cnt_gate_o, 0);
        chk("bp_valid", result_valid_o, 1);
      end
    end
    result_ready_i = 1; step(); result_ready_i = 0; continuous_i = 0; acc++;
    chk("bp_clear", cnt_clear_o, 1);
    chk("bp_busy", busy_o, 1);
    chk("bp_valid_drop", result_valid_o, 0);
    chk("bp_wid", window_id_o, acc % 16);
    wait_valid("bp2_valid_timeout");
    chk("bp2_result", result_o, 5);
    result_ready_i = 1; step(); result_ready_i = 0; acc++;
    chk("bp2_wid", window_id_o, acc % 16);

    // Abort in MEASURE cycle 5 with start also high.
    win_len_i = 10; start_i = 1; step(); start_i = 0;
    repeat (C + 4) step();
    abort_i = 1; start_i = 1; step(); abort_i = 0; start_i = 0;
    chk("ab_busy", busy_o, 0);
    chk("ab_gate", cnt_gate_o, 0);
    chk("ab_clear", cnt_clear_o, 1);
    chk("ab_valid", result_valid_o, 0);
    chk("ab_result", result_o, 5);
    chk("ab_wid", window_id_o, acc % 16);

    // Asynchronous reset during SETTLE.
    win_len_i = 6; start_i = 1; step(); start_i = 0;
    repeat (C + 6 + 1) step();
    #2 reset_n_i = 0;
    #1;
    chk("ar_clear", cnt_clear_o, 1);
    chk("ar_gate", cnt_gate_o, 0);
    chk("ar_valid", result_valid_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_result", result_o, 0);
    chk("ar_wid", window_id_o, 0);
    step(); step();
    reset_n_i = 1;
    repeat (4) step();
    chk("ar_no_capture", result_o, 0);

    // Randomized traffic against the model.
    per = 0;
    for (int i = 0; i < 3000; i++) begin
      start_i        = ($urandom_range(0, 5) == 0);
      win_len_i      = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      result_ready_i = ($urandom_range(0, 2) == 0);
      continuous_i   = $urandom_range(0, 1);
      abort_i        = ($urandom_range(0, 49) == 0);
      step();
    end
    start_i = 0; abort_i = 0; result_ready_i = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xtalk_window_ctrl.md
Name: xtalk_window_ctrl

Overview:
Sequences the 8-bit crosstalk event counter on the user IO pins through fixed measurement windows. The counter counts on the blip clock.
- Holds the counter in reset (clear) while idle.
- Opens a gate for a programmed number of system clocks.
- Waits for the counter value to settle, then captures it into a result register offered over a valid/ready handshake.
- Runs once per start, or back-to-back windows in continuous mode.

Parameters:
COUNT_W, 8, width of external event counter and result
WIN_W, 16, width of window-length field
CLEAR_CYCLES, 2, cycles cnt_clear held before each window (>=1)
SETTLE_CYCLES, 3, cycles after gate closes before capture (>=2, covers blip-domain settling)

Ports:
clk  in  1  system clock, single clock domain
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a measurement
continuous  in  1  when high, re-arm automatically after each accepted result
abort  in  1  return to IDLE from any state
win_len  in  WIN_W  window length in clk cycles, sampled on accepted start
cnt_value  in  COUNT_W  current external counter value
cnt_clear  out  1  drives counter reset, active high
cnt_gate  out  1  enables blip events into the counter
result  out  COUNT_W  captured count
result_sat  out  1  captured count == all-ones (counter saturated/wrapped, unreliable)
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
window_id  out  4  number of results accepted, mod 16
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert by the flops):
  - State: IDLE.
  - Outputs: cnt_clear=1, cnt_gate=0, result=0, result_sat=0, result_valid=0, window_id=0, busy=0.
- States:
  - IDLE:
    - cnt_clear=1, gate=0.
    - start=1 and win_len!=0: latch win_len into win_q, go to CLEAR.
    - start with win_len==0 is ignored; stay IDLE.
  - CLEAR: cnt_clear=1 for exactly CLEAR_CYCLES cycles, then MEASURE.
  - MEASURE: cnt_clear=0, cnt_gate=1 for exactly win_q cycles, then SETTLE.
  - SETTLE:
    - clear=0, gate=0 for SETTLE_CYCLES cycles.
    - On the last SETTLE cycle, cnt_value is registered into result; result_sat = (cnt_value == all-ones).
    - Next state: HOLD.
  - HOLD:
    - result_valid=1; clear=0 and gate=0, so the counter value is frozen.
    - On result_valid & result_ready: window_id increments; result_valid drops next cycle.
    - Next state: CLEAR if continuous=1 (win_q reused, win_len not re-sampled), else IDLE.
- Latency: start sampled at edge 0.
  - CLEAR occupies cycles 1..C.
  - MEASURE occupies cycles C+1..C+W.
  - SETTLE occupies cycles C+W+1..C+W+S.
  - result_valid is first high in cycle C+W+S+1.
- Output timing: all outputs are registered. cnt_gate is high for exactly W cycles per window.
- Backpressure: HOLD waits indefinitely. No window starts until the result is accepted, so results are never lost or overwritten.
- start while busy: ignored; it does not queue.
- abort:
  - Priority over start and handshake, from any non-IDLE state.
  - Next state IDLE: gate=0, clear=1, result_valid=0.
  - result, result_sat and window_id retain their values.
  - abort in IDLE has no effect.
- continuous deasserted mid-window: takes effect at the HOLD handshake only.
- Counters:
  - Phase timer is a down-counter sized max(WIN_W, clog2 of the larger of the CLEAR/SETTLE parameters).
  - window_id wraps 15 -> 0.
- win_len = max (all-ones) is legal and gives a window of 2^WIN_W-1 cycles.

Decomposition:
- Package xtalk_pkg holds:
  - state enum (IDLE, CLEAR, MEASURE, SETTLE, HOLD);
  - default widths COUNT_W/WIN_W;
  - CLEAR_CYCLES/SETTLE_CYCLES defaults;
  - the window_id width constant.
- One sub-module, xtalk_phase_timer: loadable down-counter with load/value/done.
  - It is reloaded by the FSM on each CLEAR/MEASURE/SETTLE entry.
  - done asserts in the phase's final cycle.
- FSM, capture register and handshake stay in xtalk_window_ctrl.

Test Plan:
- Reset, then start with win_len=10, counter model incrementing every 3rd cycle while gated -> cnt_clear high cycles 1-2, cnt_gate high exactly cycles 3-12, result_valid at cycle 16 with result=3 (or the model's exact count), result_sat=0, window_id=1 after ready.
- start with win_len=0, then start asserted during MEASURE -> both ignored; busy stays low after the first and the second window is unaffected.
- Hold result_ready=0 for 20 cycles in HOLD with continuous=1, counter model still toggling -> result stable, gate=0 throughout, next CLEAR begins cycle after ready=1; window_id increments once.
- Counter model reaching 8'hFF during window -> result=8'hFF, result_sat=1.
- abort asserted in MEASURE cycle 5 with start also high -> next cycle IDLE, gate=0, clear=1, result_valid=0, previous result/window_id unchanged.
- Async reset_n pulse mid-SETTLE -> all outputs immediately at reset values; no capture.
